tt_nibble_alu_acc: RTL and testbench
====================================

Name: tt_nibble_alu_acc

Overview:
Parametrised, registered successor to the single-nibble adder.
- Splits a 2*W-bit operand bus into A (upper half) and B (lower half).
- Performs one of four operations: add, subtract, accumulate or clear.
- Holds a running accumulator and presents a registered result, flags and a valid strobe one cycle later.
- Sits between the pad-level input bus and the output pins of the tile top level.

Parameters:
- W, 4, operand width in bits; the input bus is 2*W wide.
- ACC_W, 8, accumulator and result width; must satisfy ACC_W >= W+1.
- SATURATE, 0, 0 = accumulator wraps modulo 2^ACC_W; 1 = accumulator clamps at 2^ACC_W-1.
- CNT_W, 8, width of the operation counter.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand and op are sampled when high.
- op  in  2  00 ADD, 01 SUB, 10 ACC, 11 CLR.
- operands  in  2*W  A = operands[2W-1:W], B = operands[W-1:0].
- result  out  ACC_W  registered result.
- carry  out  1  carry (ADD/ACC) or borrow (SUB) of the last operation.
- zero  out  1  high when result == 0.
- out_valid  out  1  one-cycle pulse; result and flags are fresh.
- op_count  out  CNT_W  number of accepted operations, saturating.

Behaviour:
- Reset (async assert, sync release): result=0, carry=0, zero=1, out_valid=0, op_count=0, accumulator=0.
- Latency: an operation accepted on edge N has result, flags and out_valid=1 visible after edge N+1 (one register stage).
- No back-pressure; every in_valid cycle is accepted. Back-to-back valids give back-to-back out_valid pulses.
- in_valid low: out_valid=0 next cycle. result, carry, zero and the accumulator hold their values.
- ADD: sum = A+B computed in W+1 bits, zero-extended to ACC_W. carry = bit W of the sum. Accumulator unchanged.
- SUB: result = (A-B) in ACC_W-bit two's complement, sign-extended. carry = 1 iff A<B (borrow). Accumulator unchanged.
- ACC: t = acc + A + B computed in ACC_W+1 bits. carry = t[ACC_W].
  - SATURATE=0: acc_next = t[ACC_W-1:0].
  - SATURATE=1 and carry: acc_next = all ones.
  - result = acc_next.
- CLR: acc_next=0, result=0, carry=0.
- zero always reflects the newly registered result.
- op_count increments on every accepted op, CLR included. It stops at 2^CNT_W-1 and never wraps. Only reset clears it.
- The accumulator value used is the one registered before the current edge, so back-to-back ACC ops chain correctly with no hazard.
- Reset asserted mid-stream: all state returns to reset values immediately. The first op after release behaves as if from a fresh start, with no residual out_valid pulse.
- op is only decoded when in_valid=1. X on op or operands while in_valid=0 must not propagate to any output.

Decomposition:
- Shared package tt_alu_pkg holds:
  - op encodings as localparams OP_ADD=2'b00, OP_SUB=2'b01, OP_ACC=2'b10, OP_CLR=2'b11;
  - the default W and ACC_W constants.
- One natural sub-module: tt_sat_add. It is a combinational ACC_W-bit adder with carry-out and a SATURATE clamp, reused for the ACC path.
- Control and registers stay in the top module.

Test Plan (W=4, ACC_W=8 unless stated):
1. Reset, then ADD with operands=8'hF7 (A=15, B=7) -> next cycle result=8'h16, carry=1, zero=0, out_valid=1, op_count=1.
2. SUB with A=3, B=5 -> result=8'hFE, carry=1. Then SUB with A=5, B=5 -> result=0, zero=1, carry=0.
3. Back-to-back ACC with A=15, B=15, 9 cycles, SATURATE=0 -> acc steps 30, 60, ..., 240, then 14 with carry=1 on the 9th result. Repeat with SATURATE=1 -> 9th result=8'hFF, carry=1, and it stays 8'hFF on the next ACC.
4. ACC to 30, then an in_valid=0 gap of 3 cycles, then ACC -> result 60. During the gap out_valid=0 and result stays 30. Then CLR -> result=0, zero=1; the next ACC with A=1, B=0 gives result=1.
5. Assert reset on the same edge as an accepted ACC -> all outputs at reset values, no out_valid pulse. After release, ACC with A=2, B=3 gives result=5.
6. CNT_W=2: issue 5 ops -> op_count reads 1, 2, 3, 3, 3.

Source files
------------

// File: rtl/tt_alu_pkg.sv
// Shared constants for the nibble ALU/accumulator tile: op encodings and default widths.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package tt_alu_pkg;

  // Operation encodings carried on the 2-bit op input.
  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_ACC = 2'b10;
  localparam logic [1:0] OP_CLR = 2'b11;

  // Default geometry: 4-bit operands, 8-bit accumulator/result, 8-bit op counter.
  localparam int DEF_W     = 4;
  localparam int DEF_ACC_W = 8;
  localparam int DEF_CNT_W = 8;

endpackage

// File: rtl/tt_sat_add.sv
// Combinational ACC_W-bit adder with carry-out and optional clamp to all-ones on overflow.
// Latency: zero cycles (purely combinational).
// Backpressure: none; output follows inputs.
module tt_sat_add #(
  parameter int ACC_W    = 8,
  parameter int SATURATE = 0
) (
  input  logic [ACC_W-1:0] i_a,
  input  logic [ACC_W-1:0] i_b,
  output logic [ACC_W-1:0] o_sum,
  output logic             o_carry
);

  logic [ACC_W:0] w_t;

  // Full-width sum so the carry is the true overflow bit; clamp only when enabled.
  always_comb begin
    w_t     = {1'b0, i_a} + {1'b0, i_b};
    o_carry = w_t[ACC_W];
    if ((SATURATE != 0) && w_t[ACC_W]) begin
      o_sum = {ACC_W{1'b1}};
    end else begin
      o_sum = w_t[ACC_W-1:0];
    end
  end

endmodule

// File: rtl/tt_nibble_alu_acc.sv
// Registered nibble ALU: ADD/SUB/ACC/CLR on the two halves of the operand bus, running accumulator.
// Latency: one cycle from accepted in_valid to result/flags/out_valid.
// Backpressure: none; every in_valid cycle is accepted, back-to-back ops give back-to-back pulses.
module tt_nibble_alu_acc
  import tt_alu_pkg::*;
#(
  parameter int W        = DEF_W,
  parameter int ACC_W    = DEF_ACC_W,
  parameter int SATURATE = 0,
  parameter int CNT_W    = DEF_CNT_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  input  logic [1:0]         op,
  input  logic [2*W-1:0]     operands,
  output logic [ACC_W-1:0]   result,
  output logic               carry,
  output logic               zero,
  output logic               out_valid,
  output logic [CNT_W-1:0]   op_count
);

  // Architectural state.
  logic [ACC_W-1:0] r_acc;
  logic [ACC_W-1:0] r_result;
  logic             r_carry;
  logic             r_zero;
  logic             r_out_valid;
  logic [CNT_W-1:0] r_op_count;

  // Operand split and datapath wires.
  logic [W-1:0]     w_a;
  logic [W-1:0]     w_b;
  logic [ACC_W-1:0] w_a_ext;
  logic [ACC_W-1:0] w_b_ext;
  logic [ACC_W-1:0] w_ab_sum;
  logic [ACC_W-1:0] w_sub_res;
  logic             w_sub_borrow;
  logic [ACC_W-1:0] w_acc_sum;
  logic             w_acc_carry;

  // Next-state wires.
  logic [ACC_W-1:0] w_nxt_acc;
  logic [ACC_W-1:0] w_nxt_result;
  logic             w_nxt_carry;
  logic             w_nxt_zero;
  logic             w_nxt_out_valid;
  logic [CNT_W-1:0] w_nxt_op_count;
  logic             w_cnt_full;

  // Split the bus and form the shared A+B term. ACC_W >= W+1 means A+B never overflows here,
  // so bit W of this sum is the ADD carry and the whole value feeds the ACC adder directly.
  always_comb begin
    w_a          = operands[2*W-1:W];
    w_b          = operands[W-1:0];
    w_a_ext      = {{(ACC_W-W){1'b0}}, w_a};
    w_b_ext      = {{(ACC_W-W){1'b0}}, w_b};
    w_ab_sum     = w_a_ext + w_b_ext;
    // Subtracting zero-extended values in ACC_W bits yields the sign-extended difference.
    w_sub_res    = w_a_ext - w_b_ext;
    w_sub_borrow = (w_a < w_b);
  end

  // Accumulate path: acc + (A+B) with wrap or clamp; uses the acc registered before this edge.
  tt_sat_add #(
    .ACC_W    (ACC_W),
    .SATURATE (SATURATE)
  ) u_sat_add (
    .i_a     (r_acc),
    .i_b     (w_ab_sum),
    .o_sum   (w_acc_sum),
    .o_carry (w_acc_carry)
  );

  assign w_cnt_full = (r_op_count == {CNT_W{1'b1}});

  // Decode op only when in_valid is high so idle-cycle garbage on op/operands cannot leak out.
  always_comb begin
    w_nxt_acc       = r_acc;
    w_nxt_result    = r_result;
    w_nxt_carry     = r_carry;
    w_nxt_out_valid = 1'b0;
    w_nxt_op_count  = r_op_count;
    if (in_valid) begin
      w_nxt_out_valid = 1'b1;
      if (!w_cnt_full) begin
        w_nxt_op_count = r_op_count + 1'b1;
      end
      case (op)
        OP_ADD: begin
          w_nxt_result = w_ab_sum;
          w_nxt_carry  = w_ab_sum[W];
        end
        OP_SUB: begin
          w_nxt_result = w_sub_res;
          w_nxt_carry  = w_sub_borrow;
        end
        OP_ACC: begin
          w_nxt_acc    = w_acc_sum;
          w_nxt_result = w_acc_sum;
          w_nxt_carry  = w_acc_carry;
        end
        default: begin
          w_nxt_acc    = '0;
          w_nxt_result = '0;
          w_nxt_carry  = 1'b0;
        end
      endcase
    end
    // Zero tracks whatever result is about to be registered (held value when idle).
    w_nxt_zero = (w_nxt_result == '0);
  end

  // State registers; asynchronous reset returns everything to a fresh-start state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_acc       <= '0;
      r_result    <= '0;
      r_carry     <= 1'b0;
      r_zero      <= 1'b1;
      r_out_valid <= 1'b0;
      r_op_count  <= '0;
    end else begin
      r_acc       <= w_nxt_acc;
      r_result    <= w_nxt_result;
      r_carry     <= w_nxt_carry;
      r_zero      <= w_nxt_zero;
      r_out_valid <= w_nxt_out_valid;
      r_op_count  <= w_nxt_op_count;
    end
  end

  assign result    = r_result;
  assign carry     = r_carry;
  assign zero      = r_zero;
  assign out_valid = r_out_valid;
  assign op_count  = r_op_count;

endmodule

// File: tb/tb_tt_nibble_alu_acc.sv
// Directed bench for tt_nibble_alu_acc: vector table plus reset and parameter corner sequences.
// Latency: checks outputs one cycle after each driven op.
// Backpressure: none exercised; DUT always accepts.
module tb_tt_nibble_alu_acc;
  import tt_alu_pkg::*;

  logic       clk;
  logic       reset;
  logic       in_valid;
  logic [1:0] op;
  logic [7:0] operands;

  logic [7:0] res0, res_s, res_c;
  logic       c0, c_s, c_c;
  logic       z0, z_s, z_c;
  logic       v0, v_s, v_c;
  logic [7:0] cnt0, cnt_s;
  logic [1:0] cnt_c;

  tt_nibble_alu_acc #(.W(4), .ACC_W(8), .SATURATE(0), .CNT_W(8)) u_dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .op(op), .operands(operands),
    .result(res0), .carry(c0), .zero(z0), .out_valid(v0), .op_count(cnt0));

  tt_nibble_alu_acc #(.W(4), .ACC_W(8), .SATURATE(1), .CNT_W(8)) u_dut_sat (
    .clk(clk), .reset(reset), .in_valid(in_valid), .op(op), .operands(operands),
    .result(res_s), .carry(c_s), .zero(z_s), .out_valid(v_s), .op_count(cnt_s));

  tt_nibble_alu_acc #(.W(4), .ACC_W(8), .SATURATE(0), .CNT_W(2)) u_dut_cnt (
    .clk(clk), .reset(reset), .in_valid(in_valid), .op(op), .operands(operands),
    .result(res_c), .carry(c_c), .zero(z_c), .out_valid(v_c), .op_count(cnt_c));

  typedef struct packed {
    logic       iv;
    logic [1:0] op;
    logic [7:0] opnd;
    logic [7:0] res;
    logic       c;
    logic       z;
    logic       ov;
    logic [7:0] cnt;
  } vec_t;

  vec_t vecs [64];
  int   n_vec;
  int   n_applied;
  int   n_fail;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic add_vec(input logic iv, input logic [1:0] o, input logic [7:0] d,
                         input logic [7:0] r, input logic c, input logic z,
                         input logic ov, input logic [7:0] cnt);
    vecs[n_vec] = '{iv: iv, op: o, opnd: d, res: r, c: c, z: z, ov: ov, cnt: cnt};
    n_vec = n_vec + 1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_applied = n_applied + 1;
    if (act !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic iv, input logic [1:0] o, input logic [7:0] d);
    @(negedge clk);
    in_valid = iv;
    if (iv) begin
      op       = o;
      operands = d;
    end else begin
      op       = 'x;
      operands = 'x;
    end
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] tup0();
    return {13'd0, res0, c0, z0, v0, cnt0};
  endfunction

  initial begin
    int acc_k;
    n_vec = 0; n_applied = 0; n_fail = 0;

    // Main table: {in_valid, op, operands} -> {result, carry, zero, out_valid, op_count}.
    add_vec(1, OP_ADD, 8'hF7, 8'h16, 1, 0, 1, 8'd1);
    add_vec(1, OP_SUB, 8'h35, 8'hFE, 1, 0, 1, 8'd2);
    add_vec(1, OP_SUB, 8'h55, 8'h00, 0, 1, 1, 8'd3);
    add_vec(1, OP_CLR, 8'hA5, 8'h00, 0, 1, 1, 8'd4);
    add_vec(1, OP_ACC, 8'hFF, 8'h1E, 0, 0, 1, 8'd5);
    add_vec(1, OP_ACC, 8'hFF, 8'h3C, 0, 0, 1, 8'd6);
    add_vec(1, OP_ACC, 8'hFF, 8'h5A, 0, 0, 1, 8'd7);
    add_vec(1, OP_ACC, 8'hFF, 8'h78, 0, 0, 1, 8'd8);
    add_vec(1, OP_ACC, 8'hFF, 8'h96, 0, 0, 1, 8'd9);
    add_vec(1, OP_ACC, 8'hFF, 8'hB4, 0, 0, 1, 8'd10);
    add_vec(1, OP_ACC, 8'hFF, 8'hD2, 0, 0, 1, 8'd11);
    add_vec(1, OP_ACC, 8'hFF, 8'hF0, 0, 0, 1, 8'd12);
    add_vec(1, OP_ACC, 8'hFF, 8'h0E, 1, 0, 1, 8'd13);
    add_vec(1, OP_CLR, 8'h00, 8'h00, 0, 1, 1, 8'd14);
    add_vec(1, OP_ACC, 8'hFF, 8'h1E, 0, 0, 1, 8'd15);
    add_vec(0, OP_ADD, 8'h00, 8'h1E, 0, 0, 0, 8'd15);
    add_vec(0, OP_ADD, 8'h00, 8'h1E, 0, 0, 0, 8'd15);
    add_vec(0, OP_ADD, 8'h00, 8'h1E, 0, 0, 0, 8'd15);
    add_vec(1, OP_ACC, 8'hFF, 8'h3C, 0, 0, 1, 8'd16);
    add_vec(1, OP_CLR, 8'hFF, 8'h00, 0, 1, 1, 8'd17);
    add_vec(1, OP_ACC, 8'h10, 8'h01, 0, 0, 1, 8'd18);
    add_vec(1, OP_ADD, 8'hF7, 8'h16, 1, 0, 1, 8'd19);
    add_vec(0, OP_ADD, 8'h00, 8'h16, 1, 0, 0, 8'd19);
    add_vec(1, OP_ADD, 8'h00, 8'h00, 0, 1, 1, 8'd20);
    add_vec(1, OP_SUB, 8'hF0, 8'h0F, 0, 0, 1, 8'd21);
    add_vec(1, OP_SUB, 8'h0F, 8'hF1, 1, 0, 1, 8'd22);

    reset = 1'b1; in_valid = 1'b0; op = OP_ADD; operands = 8'h00;
    @(posedge clk); @(posedge clk); #1;
    check("reset_state", tup0(), {13'd0, 8'h00, 1'b0, 1'b1, 1'b0, 8'd0});
    check("reset_cnt2", {30'd0, cnt_c}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < n_vec; i++) begin
      drive(vecs[i].iv, vecs[i].op, vecs[i].opnd);
      check($sformatf("vec%0d", i), tup0(),
            {13'd0, vecs[i].res, vecs[i].c, vecs[i].z, vecs[i].ov, vecs[i].cnt});
    end

    // Reset asserted on the same edge an ACC would be accepted.
    @(negedge clk);
    in_valid = 1'b1; op = OP_ACC; operands = 8'hFF;
    #2 reset = 1'b1;
    @(posedge clk); #1;
    check("reset_on_acc_edge", tup0(), {13'd0, 8'h00, 1'b0, 1'b1, 1'b0, 8'd0});
    @(negedge clk);
    reset = 1'b0; in_valid = 1'b0;
    @(posedge clk); #1;
    check("post_reset_idle", tup0(), {13'd0, 8'h00, 1'b0, 1'b1, 1'b0, 8'd0});
    drive(1, OP_ACC, 8'h23);
    check("post_reset_acc", tup0(), {13'd0, 8'h05, 1'b0, 1'b0, 1'b1, 8'd1});

    // Fresh reset, then chained ACC: saturating instance and 2-bit counter instance.
    @(negedge clk);
    reset = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      drive(1, OP_ACC, 8'hFF);
      acc_k = (30 * k > 255) ? 255 : 30 * k;
      check($sformatf("sat_acc%0d", k), {23'd0, res_s, c_s},
            {23'd0, acc_k[7:0], (k >= 9) ? 1'b1 : 1'b0});
      if (k <= 5) begin
        check($sformatf("cnt2_op%0d", k), {30'd0, cnt_c},
              (k > 3) ? 32'd3 : k);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_fail);
    $finish;
  end

endmodule
